mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : two-port fair arbiter in front of a single-port data memory
// rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_BITS = 14,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [31:0]      addr_a,
  input  logic [31:0]      wdata_a,
  output logic             ack_a,
  output logic             err_a,
  output logic [31:0]      rdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [31:0]      addr_b,
  input  logic [31:0]      wdata_b,
  output logic             ack_b,
  output logic             err_b,
  output logic [31:0]      rdata_b,
  output logic [31:0]      mem_address,
  output logic             mem_writeEnable,
  output logic [31:0]      mem_dataIn,
  input  logic [31:0]      mem_dataOut,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   last_served;  // 1 = B served last, so A wins the next tie
  logic   range_err_a;
  logic   range_err_b;

  assign range_err_a = |addr_a[31:ADDR_BITS];
  assign range_err_b = |addr_b[31:ADDR_BITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      rdata_a     <= '0;
      rdata_b     <= '0;
      count_a     <= '0;
      count_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a && (!req_b || last_served))
            state <= GRANT_A;
          else if (req_b)
            state <= GRANT_B;
        end
        GRANT_A: begin
          last_served <= 1'b0;
          if (!we_a)
            rdata_a <= range_err_a ? '0 : mem_dataOut;
          if (!range_err_a && (count_a != {CNT_W{1'b1}}))
            count_a <= count_a + cnt_one;
          state <= req_b ? GRANT_B : IDLE;
        end
        GRANT_B: begin
          last_served <= 1'b1;
          if (!we_b)
            rdata_b <= range_err_b ? '0 : mem_dataOut;
          if (!range_err_b && (count_b != {CNT_W{1'b1}}))
            count_b <= count_b + cnt_one;
          state <= req_a ? GRANT_A : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grant-side outputs decode straight from the state register, so an async
  // reset drops the memory write enable in the same instant.
  assign ack_a = (state == GRANT_A);
  assign ack_b = (state == GRANT_B);
  assign err_a = ack_a & range_err_a;
  assign err_b = ack_b & range_err_b;

  always_comb begin
    mem_address     = '0;
    mem_dataIn      = '0;
    mem_writeEnable = 1'b0;
    case (state)
      GRANT_A: begin
        mem_address     = addr_a;
        mem_dataIn      = wdata_a;
        mem_writeEnable = we_a & ~range_err_a;
      end
      GRANT_B: begin
        mem_address     = addr_b;
        mem_dataIn      = wdata_b;
        mem_writeEnable = we_b & ~range_err_b;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_BITS = 14;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_a, we_a, req_b, we_b;
  logic [31:0]      addr_a, wdata_a, addr_b, wdata_b;
  logic             ack_a, err_a, ack_b, err_b;
  logic [31:0]      rdata_a, rdata_b;
  logic [31:0]      mem_address, mem_dataIn, mem_dataOut;
  logic             mem_writeEnable;
  logic [CNT_W-1:0] count_a, count_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  assign mem_dataOut = mem[mem_address[7:0]];
  always @(posedge clk)
    if (mem_writeEnable) mem[mem_address[7:0]] <= mem_dataIn;

  mem_arbiter #(.ADDR_BITS(ADDR_BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .err_a(err_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .err_b(err_b), .rdata_b(rdata_b),
    .mem_address(mem_address), .mem_writeEnable(mem_writeEnable),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut),
    .count_a(count_a), .count_b(count_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    clear_inputs();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic access_a(input logic we, input logic [31:0] addr, input logic [31:0] data);
    req_a = 1; we_a = we; addr_a = addr; wdata_a = data;
    tick();
    tick();
    req_a = 0; we_a = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack_a"}, {31'b0, ack_a}, 0);
    chk({tag, "_ack_b"}, {31'b0, ack_b}, 0);
    chk({tag, "_err_a"}, {31'b0, err_a}, 0);
    chk({tag, "_err_b"}, {31'b0, err_b}, 0);
    chk({tag, "_rdata_a"}, rdata_a, 0);
    chk({tag, "_rdata_b"}, rdata_b, 0);
    chk({tag, "_count_a"}, {28'b0, count_a}, 0);
    chk({tag, "_count_b"}, {28'b0, count_b}, 0);
    chk({tag, "_mem_we"}, {31'b0, mem_writeEnable}, 0);
    chk({tag, "_mem_addr"}, mem_address, 0);
    chk({tag, "_mem_din"}, mem_dataIn, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h20] = 32'h12345678;
    clear_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1;

    // Request that vanishes before any edge samples it
    req_a = 1;
    #1 req_a = 0;
    tick();
    chk("glitch_ack_a", {31'b0, ack_a}, 0);
    chk("glitch_count_a", {28'b0, count_a}, 0);

    // Single A write then A read of the same word
    req_a = 1; we_a = 1; addr_a = 32'h10; wdata_a = 32'hF83E0F83;
    tick();
    chk("wr_ack_a", {31'b0, ack_a}, 1);
    chk("wr_mem_we", {31'b0, mem_writeEnable}, 1);
    chk("wr_mem_addr", mem_address, 32'h10);
    chk("wr_mem_din", mem_dataIn, 32'hF83E0F83);
    tick();
    chk("wr_idle_ack_a", {31'b0, ack_a}, 0);
    chk("wr_count_a", {28'b0, count_a}, 1);
    chk("wr_idle_mem_addr", mem_address, 0);
    we_a = 0;
    tick();
    chk("rd_ack_a", {31'b0, ack_a}, 1);
    chk("rd_mem_we", {31'b0, mem_writeEnable}, 0);
    tick();
    req_a = 0;
    chk("rd_rdata_a", rdata_a, 32'hF83E0F83);
    chk("rd_count_a", {28'b0, count_a}, 2);
    chk("rd_done_ack_a", {31'b0, ack_a}, 0);

    // Tie on the first cycle after reset: A first, then B
    do_reset();
    req_a = 1; addr_a = 32'h10; req_b = 1; addr_b = 32'h20;
    tick();
    chk("tie_ack_a", {31'b0, ack_a}, 1);
    chk("tie_ack_b0", {31'b0, ack_b}, 0);
    tick();
    req_a = 0;
    chk("tie_ack_a0", {31'b0, ack_a}, 0);
    chk("tie_ack_b", {31'b0, ack_b}, 1);
    chk("tie_rdata_a", rdata_a, 32'hF83E0F83);
    tick();
    req_b = 0;
    chk("tie_end_ack_b", {31'b0, ack_b}, 0);
    chk("tie_rdata_b", rdata_b, 32'h12345678);
    chk("tie_count_a", {28'b0, count_a}, 1);
    chk("tie_count_b", {28'b0, count_b}, 1);

    // Continuous back-to-back requests from both sides for 8 grants
    do_reset();
    req_a = 1; addr_a = 32'h10; req_b = 1; addr_b = 32'h20;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("alt%0d_ack_a", i), {31'b0, ack_a}, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d_ack_b", i), {31'b0, ack_b}, (i % 2 == 1) ? 1 : 0);
      if (i == 7) req_a = 0;
    end
    tick();
    req_b = 0;
    chk("alt_end_ack_a", {31'b0, ack_a}, 0);
    chk("alt_end_ack_b", {31'b0, ack_b}, 0);
    chk("alt_count_a", {28'b0, count_a}, 4);
    chk("alt_count_b", {28'b0, count_b}, 4);
    chk("alt_rdata_a", rdata_a, 32'hF83E0F83);
    chk("alt_rdata_b", rdata_b, 32'h12345678);

    // Out-of-range B write
    req_b = 1; we_b = 1; addr_b = 32'h00004000; wdata_b = 32'hDEADBEEF;
    tick();
    chk("oor_ack_b", {31'b0, ack_b}, 1);
    chk("oor_err_b", {31'b0, err_b}, 1);
    chk("oor_err_a", {31'b0, err_a}, 0);
    chk("oor_mem_we", {31'b0, mem_writeEnable}, 0);
    tick();
    req_b = 0; we_b = 0;
    chk("oor_err_b_idle", {31'b0, err_b}, 0);
    chk("oor_count_b", {28'b0, count_b}, 4);
    chk("oor_rdata_b", rdata_b, 32'h12345678);
    chk("oor_mem0", mem[8'h00], 0);

    // Reset pulled low in the middle of a B write grant
    req_b = 1; we_b = 1; addr_b = 32'h30; wdata_b = 32'hA5A5A5A5;
    tick();
    chk("abort_pre_ack_b", {31'b0, ack_b}, 1);
    chk("abort_pre_mem_we", {31'b0, mem_writeEnable}, 1);
    #2 reset_n = 0;
    #1;
    chk("abort_mem_we", {31'b0, mem_writeEnable}, 0);
    chk("abort_ack_b", {31'b0, ack_b}, 0);
    clear_inputs();
    tick();
    @(negedge clk);
    reset_n = 1;
    #1;
    chk_reset_outputs("abort");
    chk("abort_mem30", mem[8'h30], 0);

    // Counter saturation at all-ones
    do_reset();
    for (int i = 0; i < 15; i++) access_a(1'b1, 32'h40, i);
    chk("sat_count_15", {28'b0, count_a}, 32'hF);
    access_a(1'b1, 32'h40, 32'h55);
    chk("sat_count_16", {28'b0, count_a}, 32'hF);
    access_a(1'b0, 32'h40, 32'h0);
    chk("sat_count_17", {28'b0, count_a}, 32'hF);
    chk("sat_rdata_a", rdata_a, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
